// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// nibble_serial_adder_ctrl_pkg
//   Types and constants shared by the nibble-serial adder service.
//   state_t : sequencer state, IDLE -> RUN -> DONE -> IDLE.
package nibble_serial_adder_ctrl_pkg;

   localparam int NIBBLE_BITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder4_cin.sv
// adder4_cin
//   Four-full-adder ripple chain with the carry-in of the first stage
//   exposed, so that a wide add can be chained one nibble at a time.
//   a, b : 4-bit addends
//   cin  : carry into bit 0
//   s    : {carry out, 4-bit sum}
module adder4_cin (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [4:0] s
);

   logic [4:0] c;

   // NOTE: combinational logic uses blocking '=' so each stage sees the
   // carry produced by the stage before it within the same evaluation.
   always_comb begin
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      s[4] = c[4];
   end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Shares one 4-bit adder between two requesters and performs WIDTH-bit
//   additions one nibble per cycle, least-significant nibble first.
//   WIDTH must be a multiple of 4 and at least 4.
//   clk, reset              : clock, synchronous active-high reset
//   req<n>_valid/_a/_b      : requester n operands with valid
//   req<n>_ready            : requester n accepted when valid && ready
//   res_valid               : one-cycle result pulse
//   res_sum                 : WIDTH+1 bit sum (top bit is carry out)
//   res_id                  : requester that owns res_sum
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             res_valid,
   output logic [WIDTH:0]   res_sum,
   output logic             res_id
);

   localparam int NIB   = WIDTH / NIBBLE_BITS;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   state_t           state;
   state_t           state_nx;
   logic             last_grant;
   logic             grant;
   logic             accept;
   logic             last_nib;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nx;
   logic             carry_reg;
   logic [CNT_W-1:0] nib_cnt;
   logic [4:0]       s;

   adder4_cin u_add (
      .a   (a_sh[3:0]),
      .b   (b_sh[3:0]),
      .cin (carry_reg),
      .s   (s)
   );

   // Round-robin: on a tie the requester that did not win last time wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = ~last_grant;
      else if (req1_valid)          grant = 1'b1;
   end

   assign req0_ready = (state == IDLE) && req0_valid && !grant;
   assign req1_ready = (state == IDLE) && req1_valid &&  grant;
   assign accept     = req0_ready || req1_ready;
   assign last_nib   = (nib_cnt == CNT_W'(NIB - 1));
   assign res_valid  = (state == DONE);

   // New sum nibble enters at the top; after NIB shifts the first nibble
   // has reached bit 0.
   assign sum_nx = WIDTH'({s[3:0], sum_sh} >> NIBBLE_BITS);

   // NOTE: every output of this block gets a default before the case so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)   state_nx = RUN;
         RUN:     if (last_nib) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: the datapath shift registers are reset along with the control
   // state so that an aborted operation leaves nothing behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         res_id     <= 1'b0;
         res_sum    <= '0;
         a_sh       <= '0;
         b_sh       <= '0;
         sum_sh     <= '0;
         carry_reg  <= 1'b0;
         nib_cnt    <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (accept) begin
                  a_sh       <= grant ? req1_a : req0_a;
                  b_sh       <= grant ? req1_b : req0_b;
                  res_id     <= grant;
                  last_grant <= grant;
                  carry_reg  <= 1'b0;
                  nib_cnt    <= '0;
               end
            end
            RUN: begin
               sum_sh    <= sum_nx;
               carry_reg <= s[4];
               a_sh      <= a_sh >> NIBBLE_BITS;
               b_sh      <= b_sh >> NIBBLE_BITS;
               nib_cnt   <= nib_cnt + CNT_W'(1);
               if (last_nib) res_sum <= {s[4], sum_nx};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
//   Drives a WIDTH=16 instance through directed and random operations and a
//   WIDTH=4 instance through one operation. Expected sums come from plain
//   integer addition and expected owners from a round-robin winner model.
module tb_nibble_serial_adder_ctrl;

   localparam int NIB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic        res_valid;
   logic [16:0] res_sum;
   logic        res_id;

   logic        r4_valid0, r4_valid1;
   logic [3:0]  r4_a0, r4_b0, r4_a1, r4_b1;
   logic        r4_ready0, r4_ready1;
   logic        res_valid4;
   logic [4:0]  res_sum4;
   logic        res_id4;

   int tests = 0;
   int fails = 0;
   bit model_last;

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_sum(res_sum), .res_id(res_id)
   );

   nibble_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset),
      .req0_valid(r4_valid0), .req0_a(r4_a0), .req0_b(r4_b0), .req0_ready(r4_ready0),
      .req1_valid(r4_valid1), .req1_a(r4_a1), .req1_b(r4_b1), .req1_ready(r4_ready1),
      .res_valid(res_valid4), .res_sum(res_sum4), .res_id(res_id4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] add17(input logic [15:0] a, input logic [15:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Waits (bounded) for the next result pulse; cyc counts negedges waited.
   task automatic wait_result(output int cyc);
      bit got;
      got = 1'b0;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
         if (res_valid) begin
            got = 1'b1;
            break;
         end
      end
      check("result_timeout", 32'(got), 32'd1);
   endtask

   // One operation from IDLE; valids drop right after acceptance and the
   // operand inputs are scrambled to show they are sampled only once.
   task automatic do_op(input bit v0, input bit v1,
                        input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1);
      bit          win;
      logic [16:0] exp;
      win = (v0 && v1) ? !model_last : v1;
      exp = win ? add17(a1, b1) : add17(a0, b0);
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      #1;
      check("op_rdy0", 32'(req0_ready), 32'(v0 && !win));
      check("op_rdy1", 32'(req1_ready), 32'(v1 &&  win));
      @(negedge clk);
      check("run_rdy", 32'(req0_ready | req1_ready), 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      for (int k = 1; k <= NIB + 1; k++) begin
         @(negedge clk);
         check("op_valid", 32'(res_valid), 32'(k == NIB));
         if (k >= NIB) begin
            check("op_sum", 32'(res_sum), 32'(exp));
            check("op_id", 32'(res_id), 32'(win));
         end
      end
      model_last = win;
   endtask

   initial begin
      bit          win;
      logic [16:0] exp;
      int          cyc;

      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      r4_valid0 = 1'b0; r4_valid1 = 1'b0;
      r4_a0 = '0; r4_b0 = '0; r4_a1 = '0; r4_b1 = '0;
      model_last = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_sum", 32'(res_sum), 32'd0);
      check("rst_id", 32'(res_id), 32'd0);
      check("rst_rdy0", 32'(req0_ready), 32'd0);
      check("rst_rdy1", 32'(req1_ready), 32'd0);
      check("rst_valid4", 32'(res_valid4), 32'd0);
      check("rst_sum4", 32'(res_sum4), 32'd0);

      // Reset wins over acceptance: still IDLE after an edge with valid high.
      req0_valid = 1'b1;
      #1 check("rst_ready_idle", 32'(req0_ready), 32'd1);
      @(negedge clk);
      check("rst_prio_rdy", 32'(req0_ready), 32'd1);
      check("rst_prio_valid", 32'(res_valid), 32'd0);

      // Both valid in the first cycle after reset, held for 4 operations.
      reset = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002;
      req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'h8000;
      #1;
      check("tie_rdy0", 32'(req0_ready), 32'd1);
      check("tie_rdy1", 32'(req1_ready), 32'd0);
      for (int n = 0; n < 4; n++) begin
         win = !model_last;
         exp = win ? add17(req1_a, req1_b) : add17(req0_a, req0_b);
         wait_result(cyc);
         check("rr_gap", 32'(cyc), (n == 0) ? 32'(NIB + 1) : 32'(NIB + 2));
         check("rr_id", 32'(res_id), 32'(win));
         check("rr_sum", 32'(res_sum), 32'(exp));
         model_last = win;
         if (win) begin
            req1_a = 16'($urandom); req1_b = 16'($urandom);
         end else begin
            req0_a = 16'($urandom); req0_b = 16'($urandom);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);

      // Random mix of single and tied requests.
      for (int i = 0; i < 16; i++) begin
         bit v0, v1;
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         do_op(v0, v1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end

      // Directed operations, including a carry through every nibble.
      do_op(1'b1, 1'b0, 16'h1234, 16'h4321, 16'h0000, 16'h0000);
      do_op(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001);

      // Reset during cycle 2 of a RUN with req1 held valid.
      req1_valid = 1'b1; req1_a = 16'h0F0F; req1_b = 16'h00F1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("abort_valid", 32'(res_valid), 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      check("abort_no_pulse", 32'(res_valid), 32'd0);
      check("abort_sum", 32'(res_sum), 32'd0);
      check("abort_id", 32'(res_id), 32'd0);
      reset = 1'b0;
      model_last = 1'b1;
      #1 check("abort_rdy1", 32'(req1_ready), 32'd1);
      wait_result(cyc);
      check("abort_gap", 32'(cyc), 32'(NIB + 1));
      check("abort_res_sum", 32'(res_sum), 32'(add17(16'h0F0F, 16'h00F1)));
      check("abort_res_id", 32'(res_id), 32'd1);
      req1_valid = 1'b0;
      repeat (2) @(negedge clk);

      // WIDTH=4 instance: single nibble, result in cycle 1.
      r4_valid0 = 1'b1; r4_a0 = 4'hF; r4_b0 = 4'hF;
      #1 check("w4_rdy", 32'(r4_ready0), 32'd1);
      @(negedge clk);
      check("w4_c0_valid", 32'(res_valid4), 32'd0);
      r4_valid0 = 1'b0; r4_a0 = 4'h0; r4_b0 = 4'h0;
      @(negedge clk);
      check("w4_c1_valid", 32'(res_valid4), 32'd1);
      check("w4_sum", 32'(res_sum4), 32'(5'({1'b0, 4'hF} + 5'h0F)));
      check("w4_id", 32'(res_id4), 32'd0);
      @(negedge clk);
      check("w4_c2_valid", 32'(res_valid4), 32'd0);
      check("w4_hold", 32'(res_sum4), 32'h1E);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
